// File: rtl/txport_pkg.sv
// Shared types and constants for the transmit-port UART sink.
// The frame layout is defined here so the FSM and any future consumer agree on it.
package txport_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

endpackage

// File: rtl/txport_uart_tx_byte_fifo.sv
// Small byte FIFO with occupancy count; head byte is visible combinationally on dout.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; stale entries are unreachable because
    // the pointers and count are reset, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/txport_uart_tx.sv
// Board-side sink for the user transmit port: synchronizes the txclk strobe, buffers
// bytes in a FIFO and drains them as back-to-back 8N1 frames on serial_out.
module txport_uart_tx
    import txport_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    txdata,
    input  logic                          txclk,
    input  logic                          clr_ovf,
    output logic                          txready,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic s1, s2, s3;
    logic push_req;
    logic push_ok;
    logic pop;
    logic [7:0] fifo_dout;
    logic fifo_full;
    logic fifo_empty;
    logic [CW-1:0] count_nxt;

    uart_state_t    state, state_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]     bit_idx, bit_idx_nxt;
    logic [7:0]     shift, shift_nxt;
    logic           serial_nxt;
    logic           busy_nxt;
    logic           bit_end;

    // txclk is asynchronous to clk: two flops resolve metastability, the third finds the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= txclk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign push_req = s2 & ~s3;
    assign push_ok  = push_req & txready & ~fifo_full;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .din   (txdata),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign count_nxt = count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

    // txready follows the next-state count so it changes on the same edge as count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txready  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            txready <= (count_nxt < DEPTH_C);
            if (push_req && !txready) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bit_end = (bit_cnt == BIT_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_nxt   = fifo_dout;
                    bit_cnt_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = {1'b0, shift[7:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    // Chain straight into the next START so queued bytes leave with no idle gap.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = fifo_dout;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        case (state_nxt)
            START:   serial_nxt = 1'b0;
            DATA:    serial_nxt = shift_nxt[0];
            default: serial_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // The line level is registered from the next state, keeping serial_out glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift      <= shift_nxt;
            serial_out <= serial_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
